// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg -- definitions shared by the control FSM and the serial datapath.
//   WIDTH_DEF : default operand/result width
//   alu_op_t  : ALU operation encoding (the FSM drives this encoding)
// No ports.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,   // ADD, or SUB when sub_en is set
        ALU_XOR = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

endpackage

// File: rtl/serial_datapath_if.sv
// ---------------------------------------------------------------------------
// serial_datapath_if -- strobe/data bundle between the control FSM (master)
// and the bit-serial datapath (slave).
//   Master drives : a_data, b_data, instr, is_rtype, sub_en, load_a, load_b,
//                   shift_a, shift_b, shift_out, alu_op, carry_en, load_out
//   Slave drives  : result, result_valid, flag_c, flag_z, flag_v
// Handshake: there is no backpressure. Every strobe is a single-cycle
// command acted on at the next rising clk edge; result_valid is a one-cycle
// pulse the cycle after load_out, and the consumer must take it then.
// ---------------------------------------------------------------------------
interface serial_datapath_if #(
    parameter int WIDTH = cpu_pkg::WIDTH_DEF
);
    logic [WIDTH-1:0] a_data;
    logic [WIDTH-1:0] b_data;
    logic [11:0]      instr;
    logic             is_rtype;
    logic             sub_en;
    logic             load_a;
    logic             load_b;
    logic             shift_a;
    logic             shift_b;
    logic             shift_out;
    logic [1:0]       alu_op;
    logic             carry_en;
    logic             load_out;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             flag_c;
    logic             flag_z;
    logic             flag_v;

    modport master (
        output a_data, b_data, instr, is_rtype, sub_en, load_a, load_b,
               shift_a, shift_b, shift_out, alu_op, carry_en, load_out,
        input  result, result_valid, flag_c, flag_z, flag_v
    );

    modport slave (
        input  a_data, b_data, instr, is_rtype, sub_en, load_a, load_b,
               shift_a, shift_b, shift_out, alu_op, carry_en, load_out,
        output result, result_valid, flag_c, flag_z, flag_v
    );
endinterface

// File: rtl/serial_alu1.sv
// ---------------------------------------------------------------------------
// serial_alu1 -- combinational 1-bit ALU slice.
//   i_a, i_b : operand bits
//   i_cin    : carry in (ADD/SUB only)
//   i_sub    : inverts i_b for ADD/SUB; ignored by the logic ops
//   i_op     : cpu_pkg ALU op encoding
//   o_s      : result bit
//   o_cout   : carry out (0 for logic ops)
// ---------------------------------------------------------------------------
module serial_alu1
    import cpu_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_cin,
    input  logic       i_sub,
    input  logic [1:0] i_op,
    output logic       o_s,
    output logic       o_cout
);
    logic w_bb;

    assign w_bb = i_b ^ i_sub;

    always_comb begin
        o_s    = 1'b0;
        o_cout = 1'b0;
        case (alu_op_t'(i_op))
            ALU_ADD: begin
                o_s    = i_a ^ w_bb ^ i_cin;
                o_cout = (i_a & w_bb) | (i_a & i_cin) | (w_bb & i_cin);
            end
            ALU_XOR: o_s = i_a ^ i_b;
            ALU_AND: o_s = i_a & i_b;
            ALU_OR:  o_s = i_a | i_b;
            default: o_s = 1'b0;
        endcase
    end
endmodule

// File: rtl/serial_datapath.sv
// ---------------------------------------------------------------------------
// serial_datapath -- bit-serial execution datapath, LSB first.
// Operand shift registers A/B feed a 1-bit ALU with a carry flop; the ALU
// bit enters the MSB of result shift register R. After WIDTH shifts R holds
// the LSB-aligned result, which load_out copies into the output register.
//   clk   : system clock
//   rstn  : asynchronous active-low reset
//   bus   : serial_datapath_if.slave (strobes, operands, result, flags)
// Optional: define SERIAL_DP_OVF_EN to build the signed-overflow flag
// (bit counter + v_q flop); otherwise flag_v is tied to 0.
// ---------------------------------------------------------------------------
module serial_datapath
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IMM_W = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    serial_datapath_if.slave     bus
);
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_valid;
    logic             r_flag_c;
    logic             r_flag_z;
    logic [WIDTH-1:0] w_imm;
    logic             w_s;
    logic             w_cout;
    logic             w_is_add;
    logic             w_instr_unused;

    // Only instr[IMM_W-1:0] is the immediate; the rest is opcode/reg fields.
    assign w_instr_unused = ^bus.instr;

    always_comb begin
        w_imm              = '0;
        w_imm[IMM_W-1:0]   = bus.instr[IMM_W-1:0];
    end

    assign w_is_add = (alu_op_t'(bus.alu_op) == ALU_ADD);

    serial_alu1 u_alu (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .i_sub  (bus.sub_en),
        .i_op   (bus.alu_op),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    // Operand / result shift registers and carry: load > shift > hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a     <= '0;
            r_b     <= '0;
            r_r     <= '0;
            r_carry <= 1'b0;
        end else begin
            if (bus.load_a)
                r_a <= bus.a_data;
            else if (bus.shift_a)
                r_a <= {1'b0, r_a[WIDTH-1:1]};

            // load_b beats the I-type immediate load from load_a.
            if (bus.load_b)
                r_b <= bus.b_data;
            else if (bus.load_a && !bus.is_rtype)
                r_b <= w_imm;
            else if (bus.shift_b)
                r_b <= {1'b0, r_b[WIDTH-1:1]};

            if (bus.load_a)
                r_r <= '0;
            else if (bus.shift_out)
                r_r <= {w_s, r_r[WIDTH-1:1]};

            // Carry-in of 1 turns A + ~B into A - B.
            if (bus.load_a)
                r_carry <= bus.sub_en;
            else if (bus.shift_out && bus.carry_en && w_is_add)
                r_carry <= w_cout;
        end
    end

    // Output register: samples pre-shift R and carry on load_out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_result <= '0;
            r_valid  <= 1'b0;
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
        end else begin
            r_valid <= bus.load_out;
            if (bus.load_out) begin
                r_result <= r_r;
                r_flag_z <= (r_r == '0);
                r_flag_c <= w_is_add ? r_carry : 1'b0;
            end
        end
    end

    assign bus.result       = r_result;
    assign bus.result_valid = r_valid;
    assign bus.flag_c       = r_flag_c;
    assign bus.flag_z       = r_flag_z;

`ifdef SERIAL_DP_OVF_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_v_q;
    logic             r_flag_v;

    // Counts shift_out strobes since load_a, saturating at WIDTH. On the
    // WIDTH-th shift the ALU is working on the MSB, so r_carry is the
    // carry into the MSB and w_cout the carry out of it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bit_cnt <= '0;
            r_v_q     <= 1'b0;
            r_flag_v  <= 1'b0;
        end else begin
            if (bus.load_a) begin
                r_bit_cnt <= '0;
                r_v_q     <= 1'b0;
            end else if (bus.shift_out) begin
                if (r_bit_cnt != CNT_W'(WIDTH))
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                if (r_bit_cnt == CNT_W'(WIDTH - 1) && w_is_add)
                    r_v_q <= r_carry ^ w_cout;
            end
            if (bus.load_out)
                r_flag_v <= r_v_q;
        end
    end

    assign bus.flag_v = r_flag_v;
`else
    assign bus.flag_v = 1'b0;
`endif
endmodule

// File: tb/tb_serial_datapath.sv
// ---------------------------------------------------------------------------
// tb_serial_datapath -- directed self-checking bench for serial_datapath
// (WIDTH=8, IMM_W=8). Inputs change 1 time unit after the rising edge and
// outputs are read at the same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_serial_datapath;
    import cpu_pkg::*;

    localparam int WIDTH = 8;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    serial_datapath_if #(.WIDTH(WIDTH)) bus ();

    serial_datapath #(.WIDTH(WIDTH), .IMM_W(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.a_data    = '0;
        bus.b_data    = '0;
        bus.instr     = '0;
        bus.is_rtype  = 1'b0;
        bus.sub_en    = 1'b0;
        bus.load_a    = 1'b0;
        bus.load_b    = 1'b0;
        bus.shift_a   = 1'b0;
        bus.shift_b   = 1'b0;
        bus.shift_out = 1'b0;
        bus.alu_op    = 2'b00;
        bus.carry_en  = 1'b0;
        bus.load_out  = 1'b0;
    endtask

    // ---------------- drivers ----------------
    task automatic load_operands(input logic [7:0] a, input logic [7:0] b,
                                 input logic rtype, input logic [11:0] ins,
                                 input logic sub, input logic [1:0] op);
        bus.a_data   = a;
        bus.b_data   = b;
        bus.instr    = ins;
        bus.is_rtype = rtype;
        bus.sub_en   = sub;
        bus.alu_op   = op;
        bus.load_a   = 1'b1;
        bus.load_b   = rtype;
        step();
        bus.load_a   = 1'b0;
        bus.load_b   = 1'b0;
    endtask

    task automatic shift_n(input int n);
        bus.shift_a   = 1'b1;
        bus.shift_b   = 1'b1;
        bus.shift_out = 1'b1;
        bus.carry_en  = 1'b1;
        repeat (n) step();
        bus.shift_a   = 1'b0;
        bus.shift_b   = 1'b0;
        bus.shift_out = 1'b0;
        bus.carry_en  = 1'b0;
    endtask

    task automatic pulse_load_out();
        bus.load_out = 1'b1;
        step();
        bus.load_out = 1'b0;
    endtask

    task automatic exec_op(input logic [7:0] a, input logic [7:0] b,
                           input logic rtype, input logic [11:0] ins,
                           input logic sub, input logic [1:0] op);
        load_operands(a, b, rtype, ins, sub, op);
        shift_n(WIDTH);
        pulse_load_out();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if (bus.result !== 8'h00) begin
            errors++; $display("FAIL reset_result: got %h want 00", bus.result);
        end
        checks++;
        if (bus.result_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", bus.result_valid);
        end
        checks++;
        if ({bus.flag_c, bus.flag_z, bus.flag_v} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got cvz=%b%b%b want 000",
                               bus.flag_c, bus.flag_v, bus.flag_z);
        end
    endtask

    task automatic test_add();
        exec_op(8'h3C, 8'h05, 1'b1, 12'h000, 1'b0, ALU_ADD);
        checks++;
        if (bus.result !== 8'h41) begin
            errors++; $display("FAIL add_result: got %h want 41", bus.result);
        end
        checks++;
        if (bus.result_valid !== 1'b1) begin
            errors++; $display("FAIL add_valid: got %b want 1", bus.result_valid);
        end
        checks++;
        if ({bus.flag_c, bus.flag_z, bus.flag_v} !== 3'b000) begin
            errors++; $display("FAIL add_flags: got c=%b z=%b v=%b want 000",
                               bus.flag_c, bus.flag_z, bus.flag_v);
        end
        step();
        checks++;
        if (bus.result_valid !== 1'b0) begin
            errors++; $display("FAIL add_valid_drop: got %b want 0", bus.result_valid);
        end
        checks++;
        if (bus.result !== 8'h41) begin
            errors++; $display("FAIL add_hold: got %h want 41", bus.result);
        end
    endtask

    task automatic test_subi();
        // Upper instr bits are non-zero and must not leak into the immediate.
        exec_op(8'h05, 8'hAA, 1'b0, 12'hA05, 1'b1, ALU_ADD);
        checks++;
        if (bus.result !== 8'h00) begin
            errors++; $display("FAIL subi_eq_result: got %h want 00", bus.result);
        end
        checks++;
        if ({bus.flag_z, bus.flag_c} !== 2'b11) begin
            errors++; $display("FAIL subi_eq_flags: got z=%b c=%b want z=1 c=1",
                               bus.flag_z, bus.flag_c);
        end
        exec_op(8'h03, 8'hAA, 1'b0, 12'hF05, 1'b1, ALU_ADD);
        checks++;
        if (bus.result !== 8'hFE) begin
            errors++; $display("FAIL subi_neg_result: got %h want fe", bus.result);
        end
        checks++;
        if ({bus.flag_z, bus.flag_c} !== 2'b00) begin
            errors++; $display("FAIL subi_neg_flags: got z=%b c=%b want z=0 c=0",
                               bus.flag_z, bus.flag_c);
        end
    endtask

    task automatic test_logic();
        logic [1:0] ops [3];
        logic [7:0] exp [3];
        ops = '{ALU_XOR, ALU_AND, ALU_OR};
        exp = '{8'hCC, 8'h30, 8'hFC};
        for (int i = 0; i < 3; i++) begin
            exec_op(8'hF0, 8'h3C, 1'b1, 12'h000, 1'b0, ops[i]);
            checks++;
            if (bus.result !== exp[i]) begin
                errors++; $display("FAIL logic_op%0d_result: got %h want %h",
                                   i, bus.result, exp[i]);
            end
            checks++;
            if (bus.flag_c !== 1'b0) begin
                errors++; $display("FAIL logic_op%0d_c: got %b want 0", i, bus.flag_c);
            end
        end
        // sub_en must not invert B for logic ops; carry starts at 1 but c stays 0.
        exec_op(8'hF0, 8'h3C, 1'b1, 12'h000, 1'b1, ALU_AND);
        checks++;
        if ({bus.result, bus.flag_c} !== {8'h30, 1'b0}) begin
            errors++; $display("FAIL logic_and_sub: got %h c=%b want 30 c=0",
                               bus.result, bus.flag_c);
        end
    endtask

    task automatic test_overflow();
        logic exp_v;
`ifdef SERIAL_DP_OVF_EN
        exp_v = 1'b1;
`else
        exp_v = 1'b0;
`endif
        exec_op(8'h7F, 8'h01, 1'b1, 12'h000, 1'b0, ALU_ADD);
        checks++;
        if (bus.result !== 8'h80) begin
            errors++; $display("FAIL ovf_result: got %h want 80", bus.result);
        end
        checks++;
        if (bus.flag_c !== 1'b0) begin
            errors++; $display("FAIL ovf_c: got %b want 0", bus.flag_c);
        end
        checks++;
        if (bus.flag_v !== exp_v) begin
            errors++; $display("FAIL ovf_v: got %b want %b", bus.flag_v, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        load_operands(8'h3C, 8'h05, 1'b1, 12'h000, 1'b0, ALU_ADD);
        shift_n(4);
        bus.load_out = 1'b1;
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.result, bus.result_valid, bus.flag_c, bus.flag_z, bus.flag_v} !== 12'h000) begin
            errors++; $display("FAIL mid_reset_outputs: got r=%h vld=%b c=%b z=%b v=%b want all 0",
                               bus.result, bus.result_valid, bus.flag_c, bus.flag_z, bus.flag_v);
        end
        step();
        bus.load_out = 1'b0;
        rstn = 1'b1;
        step();
        checks++;
        if (bus.result_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_no_pulse: got %b want 0", bus.result_valid);
        end
        exec_op(8'h01, 8'h01, 1'b1, 12'h000, 1'b0, ALU_ADD);
        checks++;
        if (bus.result !== 8'h02) begin
            errors++; $display("FAIL mid_reset_fresh_add: got %h want 02", bus.result);
        end
    endtask

    task automatic test_load_priority();
        // load_a and shift_a together: A must take a_data, not a shifted value.
        bus.shift_a = 1'b1;
        bus.shift_b = 1'b1;
        load_operands(8'h81, 8'h00, 1'b1, 12'h000, 1'b0, ALU_ADD);
        shift_n(WIDTH);
        pulse_load_out();
        checks++;
        if (bus.result !== 8'h81) begin
            errors++; $display("FAIL load_beats_shift: got %h want 81", bus.result);
        end
    endtask

    task automatic test_out_during_shift();
        load_operands(8'h3C, 8'h05, 1'b1, 12'h000, 1'b0, ALU_ADD);
        shift_n(WIDTH);
        // Ninth shift with A=B=0, carry=0 shifts a 0 in: R 0x41 -> 0x20.
        bus.shift_out = 1'b1;
        bus.load_out  = 1'b1;
        step();
        bus.shift_out = 1'b0;
        bus.load_out  = 1'b0;
        checks++;
        if (bus.result !== 8'h41) begin
            errors++; $display("FAIL out_pre_shift: got %h want 41", bus.result);
        end
        pulse_load_out();
        checks++;
        if (bus.result !== 8'h20) begin
            errors++; $display("FAIL out_post_shift: got %h want 20", bus.result);
        end
    endtask

    task automatic test_back_to_back();
        exec_op(8'h10, 8'h20, 1'b1, 12'h000, 1'b0, ALU_ADD);
        // Hold load_out for two more cycles: two more valid pulses.
        bus.load_out = 1'b1;
        step();
        checks++;
        if ({bus.result_valid, bus.result} !== {1'b1, 8'h30}) begin
            errors++; $display("FAIL b2b_pulse2: got vld=%b r=%h want vld=1 r=30",
                               bus.result_valid, bus.result);
        end
        step();
        bus.load_out = 1'b0;
        checks++;
        if (bus.result_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_pulse3: got %b want 1", bus.result_valid);
        end
        step();
        checks++;
        if (bus.result_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_end: got %b want 0", bus.result_valid);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks = 0;
        errors = 0;
        clear_inputs();
        rstn = 1'b0;
        repeat (3) step();
        test_reset();
        rstn = 1'b1;
        step();
        test_add();
        test_subi();
        test_logic();
        test_overflow();
        test_reset_mid();
        test_load_priority();
        test_out_during_shift();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_datapath.md
Name: serial_datapath

Overview:
- Bit-serial execution datapath directly downstream of the control FSM.
- Holds the operand shift registers A and B, a 1-bit ALU with a carry flop, and a result shift register R.
- Executes one bit per clock, LSB first, under FSM strobes. Latches the finished word into an output register for display/writeback.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2)
- IMM_W, 8, immediate field width taken from instr[IMM_W-1:0] (IMM_W <= WIDTH, <= 12)

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- a_data  in  WIDTH  operand A source, sampled on load_a
- b_data  in  WIDTH  operand B source (R-type), sampled on load_b
- instr  in  12  instruction bits 15:4; immediate source for I-type
- is_rtype  in  1  opcode[3]; 1 = B from b_data, 0 = B from immediate
- sub_en  in  1  1 for SUB/SUBI: invert B bit, carry-in 1
- load_a  in  1  load A; also loads B with the immediate when is_rtype=0; initialises carry
- load_b  in  1  load B from b_data
- shift_a  in  1  shift A right one bit
- shift_b  in  1  shift B right one bit
- shift_out  in  1  shift ALU bit into R MSB
- alu_op  in  2  00 ADD/SUB, 01 XOR, 10 AND, 11 OR
- carry_en  in  1  carry flop updates with ALU carry-out on shift_out
- load_out  in  1  copy R into result register
- result  out  WIDTH  registered result
- result_valid  out  1  one-cycle pulse, the cycle after load_out
- flag_c  out  1  final carry (ADD/SUB only)
- flag_z  out  1  result == 0
- flag_v  out  1  signed overflow (feature-gated)

Behaviour:
- Reset (async, rstn=0): A, B, R, carry, result, result_valid, flag_c, flag_z, flag_v all 0. Reset mid-operation discards partial state; no pending output.
- load_a: A <= a_data. carry <= sub_en. If !is_rtype: B <= zero-extended instr[IMM_W-1:0]. R <= 0.
- load_b: B <= b_data. Takes priority over the immediate load if both are asserted.
- ALU bit, combinational from A[0] and B[0]: bb = B[0]^sub_en.
  - 00: s = A[0]^bb^carry; cout = maj(A[0],bb,carry)
  - 01: A[0]^B[0]
  - 10: A[0]&B[0]
  - 11: A[0]|B[0]
  - sub_en affects op 00 only.
- shift_a: A <= {0, A[WIDTH-1:1]}. shift_b likewise for B. shift_out: R <= {s, R[WIDTH-1:1]}.
- carry <= cout when shift_out && carry_en && alu_op==00. Otherwise carry holds.
- After exactly WIDTH cycles of shift_a/b/out, R holds the full result, LSB-aligned. Fewer or more shifts are not detected; the bits present are used.
- Priority per register: load > shift > hold. Load and shift in the same cycle means load wins.
- load_out: result <= R. flag_z <= (R==0). flag_c <= carry if alu_op==00, else 0. result_valid <= 1 for one cycle.
- If load_out coincides with shift_out, result takes the pre-shift R.
- Latency: result available 1 cycle after load_out. load_out held for N cycles gives N valid pulses/captures.
- Outputs hold between load_out strobes.

Optional Feature:
- Macro: SERIAL_DP_OVF_EN.
- Defined: a flop v_q captures (carry_in_of_MSB ^ cout) on the WIDTH-th ADD/SUB shift, i.e. the cycle where the shifted-in bit lands in R[WIDTH-1] as tracked by an internal bit counter cleared on load_a. flag_v <= v_q on load_out.
- Undefined: no counter/v_q logic; flag_v tied to 0.

Decomposition:
- Shared package (cpu_pkg):
  - ALU op encoding: ALU_ADD=2'b00, ALU_XOR=2'b01, ALU_AND=2'b10, ALU_OR=2'b11.
  - WIDTH default constant.
  - The FSM already uses the same ALU op encoding; move it into this package.
- Sub-module: serial_alu1 (combinational 1-bit ALU: a, b, cin, sub, op -> s, cout), reused for unit test.

Test Plan:
- ADD R-type, WIDTH=8: a=0x3C, b=0x05, 8 shifts, load_out -> result=0x41, c=0, z=0, one valid pulse next cycle.
- SUBI: a=0x05, imm=0x05, sub_en=1 -> result=0x00, z=1, c=1; a=0x03, imm=0x05 -> 0xFE, c=0.
- Logic ops: a=0xF0, b=0x3C -> XOR 0xCC, AND 0x30, OR 0xFC; c=0 each.
- Overflow with SERIAL_DP_OVF_EN: 0x7F+0x01 -> 0x80, v=1, c=0; without the macro, v=0.
- Reset mid-execute after 4 shifts -> all outputs 0, no valid pulse. A fresh ADD 0x01+0x01 then gives 0x02.
- Simultaneous load_a+shift_a: A equals a_data (load wins). load_out+shift_out: result is the pre-shift R.
